// File: rtl/addatone_pkg.sv
// Shared types and constants for the additive-synthesis sequencing blocks.
package addatone_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StStep,
    StDrain,
    StFinish
  } state_e;

  localparam int unsigned NUM_ADDERS = 2;
  localparam int unsigned DEFAULT_SAMPLE_INTERVAL = 1500;

endpackage

// File: rtl/harmonic_scheduler_if.sv
// Handshake bundle between harmonic_scheduler and its datapath neighbours.
// OVERRUN_STATS_EN adds the saturating overrun/timeout counter output.
interface harmonic_scheduler_if
  import addatone_pkg::*;
#(
  parameter int unsigned HARM_BITS = 8
);
  logic                  i_frame_start;
  logic [HARM_BITS-1:0]  i_num_harmonics;
  logic                  i_sample_ready;
  logic [NUM_ADDERS-1:0] i_adder_ready;
  logic [HARM_BITS-1:0]  o_harmonic;
  logic                  o_next_sample;
  logic [NUM_ADDERS-1:0] o_adder_start;
  logic                  o_adder_clear;
  logic                  o_scaler_start;
  logic                  o_scaler_restart;
  logic                  o_frame_done;
  logic                  o_busy;
  logic                  o_overrun;
  logic                  o_timeout;
`ifdef OVERRUN_STATS_EN
  logic [15:0]           o_overrun_count;

  modport master (
    output i_frame_start, i_num_harmonics, i_sample_ready, i_adder_ready,
    input  o_harmonic, o_next_sample, o_adder_start, o_adder_clear, o_scaler_start,
    input  o_scaler_restart, o_frame_done, o_busy, o_overrun, o_timeout, o_overrun_count
  );
  modport slave (
    input  i_frame_start, i_num_harmonics, i_sample_ready, i_adder_ready,
    output o_harmonic, o_next_sample, o_adder_start, o_adder_clear, o_scaler_start,
    output o_scaler_restart, o_frame_done, o_busy, o_overrun, o_timeout, o_overrun_count
  );
`else
  modport master (
    output i_frame_start, i_num_harmonics, i_sample_ready, i_adder_ready,
    input  o_harmonic, o_next_sample, o_adder_start, o_adder_clear, o_scaler_start,
    input  o_scaler_restart, o_frame_done, o_busy, o_overrun, o_timeout
  );
  modport slave (
    input  i_frame_start, i_num_harmonics, i_sample_ready, i_adder_ready,
    output o_harmonic, o_next_sample, o_adder_start, o_adder_clear, o_scaler_start,
    output o_scaler_restart, o_frame_done, o_busy, o_overrun, o_timeout
  );
`endif
endinterface

// File: rtl/harmonic_scheduler_frame_watchdog.sv
// Loadable down-counter; o_expired flags the last permitted active cycle of a frame.
module frame_watchdog #(
  parameter int unsigned WATCHDOG_CYCLES = 1500
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_enable,
  output logic o_expired
);
  localparam int unsigned CW = $clog2(WATCHDOG_CYCLES);
  localparam logic [CW-1:0] LoadVal = CW'(WATCHDOG_CYCLES - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      count_q <= '0;
    end else if (i_load) begin
      count_q <= LoadVal;
    end else if (i_enable && (count_q != '0)) begin
      count_q <= count_q - CW'(1);
    end
  end

  assign o_expired = i_enable && (count_q == '0);

endmodule

// File: rtl/harmonic_scheduler.sv
// Per-sample harmonic sequencer: ping-pongs issues across two adders, with watchdog abort.
// OVERRUN_STATS_EN adds a saturating count of overrun and timeout pulses.
module harmonic_scheduler
  import addatone_pkg::*;
#(
  parameter int unsigned HARM_BITS       = 8,
  parameter int unsigned MAX_HARMONICS   = 64,
  parameter int unsigned WATCHDOG_CYCLES = DEFAULT_SAMPLE_INTERVAL
) (
  input logic           i_clock,
  input logic           i_reset,
  harmonic_scheduler_if.slave bus
);
  localparam logic [HARM_BITS-1:0] MaxN = HARM_BITS'(MAX_HARMONICS);
  localparam logic [HARM_BITS-1:0] One  = HARM_BITS'(1);

  state_e                state_q, state_d;
  logic [HARM_BITS-1:0]  n_q, n_d, harm_q, harm_d, n_clamped;
  logic [NUM_ADDERS-1:0] adder_start_q, adder_start_d;
  logic next_sample_q, next_sample_d, clear_q, clear_d;
  logic sstart_q, sstart_d, srestart_q, srestart_d;
  logic done_q, done_d, busy_q, busy_d, overrun_q, overrun_d, timeout_q, timeout_d;
  logic sel, issue_ok, active, wd_load, wd_expired;

  assign sel      = harm_q[0];
  assign issue_ok = bus.i_sample_ready && bus.i_adder_ready[sel];
  assign active   = (state_q != StIdle);

  always_comb begin
    if (bus.i_num_harmonics == '0) begin
      n_clamped = One;
    end else if (bus.i_num_harmonics > MaxN) begin
      n_clamped = MaxN;
    end else begin
      n_clamped = bus.i_num_harmonics;
    end
  end

  frame_watchdog #(
    .WATCHDOG_CYCLES(WATCHDOG_CYCLES)
  ) u_watchdog (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_load   (wd_load),
    .i_enable (active),
    .o_expired(wd_expired)
  );

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    harm_d        = harm_q;
    adder_start_d = '0;
    next_sample_d = 1'b0;
    clear_d       = 1'b0;
    sstart_d      = 1'b0;
    srestart_d    = 1'b0;
    done_d        = 1'b0;
    overrun_d     = 1'b0;
    timeout_d     = 1'b0;
    wd_load       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.i_frame_start) begin
          n_d           = n_clamped;
          harm_d        = '0;
          clear_d       = 1'b1;
          srestart_d    = 1'b1;
          next_sample_d = 1'b1;
          wd_load       = 1'b1;
          state_d       = StIssue;
        end
      end
      StIssue: begin
        if (issue_ok) begin
          adder_start_d[sel] = 1'b1;
          next_sample_d      = 1'b1;
          harm_d             = harm_q + One;
          state_d            = (harm_q == n_q - One) ? StDrain : StStep;
        end
      end
      StStep: begin
        sstart_d = 1'b1;
        state_d  = StIssue;
      end
      StDrain: state_d = StFinish;
      StFinish: begin
        if (bus.i_adder_ready == 2'b11) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    overrun_d = active && bus.i_frame_start;

    // Abort wins over any issue or completion decided above.
    if (wd_expired) begin
      adder_start_d = '0;
      next_sample_d = 1'b0;
      sstart_d      = 1'b0;
      done_d        = 1'b0;
      harm_d        = harm_q;
      timeout_d     = 1'b1;
      state_d       = StIdle;
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q       <= StIdle;
      n_q           <= '0;
      harm_q        <= '0;
      adder_start_q <= '0;
      next_sample_q <= 1'b0;
      clear_q       <= 1'b0;
      sstart_q      <= 1'b0;
      srestart_q    <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      harm_q        <= harm_d;
      adder_start_q <= adder_start_d;
      next_sample_q <= next_sample_d;
      clear_q       <= clear_d;
      sstart_q      <= sstart_d;
      srestart_q    <= srestart_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
    end
  end

  assign bus.o_harmonic       = harm_q;
  assign bus.o_next_sample    = next_sample_q;
  assign bus.o_adder_start    = adder_start_q;
  assign bus.o_adder_clear    = clear_q;
  assign bus.o_scaler_start   = sstart_q;
  assign bus.o_scaler_restart = srestart_q;
  assign bus.o_frame_done     = done_q;
  assign bus.o_busy           = busy_q;
  assign bus.o_overrun        = overrun_q;
  assign bus.o_timeout        = timeout_q;

`ifdef OVERRUN_STATS_EN
  logic [15:0] ovr_count_q;
  logic [16:0] ovr_sum;

  // Counts alongside the pulses so the value is current when the pulse is seen.
  assign ovr_sum = {1'b0, ovr_count_q} + {16'd0, overrun_d} + {16'd0, timeout_d};

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      ovr_count_q <= '0;
    end else begin
      ovr_count_q <= ovr_sum[16] ? 16'hFFFF : ovr_sum[15:0];
    end
  end

  assign bus.o_overrun_count = ovr_count_q;
`endif

endmodule

// File: tb/tb_harmonic_scheduler.sv
// Self-checking bench: directed vector table, corner sequences and randomized frames vs a model.
module tb_harmonic_scheduler;
  localparam int WD   = 150;
  localparam int MAXH = 64;

  typedef struct packed {
    logic       st;
    logic [7:0] num;
    logic       sr;
    logic [1:0] ar;
  } ins_t;

  typedef struct packed {
    logic [7:0] harm;
    logic       next;
    logic [1:0] astart;
    logic       clear;
    logic       sstart;
    logic       srestart;
    logic       done;
    logic       busy;
    logic       overrun;
    logic       timeout;
  } outs_t;

  typedef struct {
    ins_t  in;
    outs_t exp;
  } vec_t;

  logic clock;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  harmonic_scheduler_if #(.HARM_BITS(8)) bus ();

  harmonic_scheduler #(
    .HARM_BITS      (8),
    .MAX_HARMONICS  (MAXH),
    .WATCHDOG_CYCLES(WD)
  ) dut (
    .i_clock(clock),
    .i_reset(reset),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  // Reference model: frame tracked as issue count plus earliest edge for the next action.
  int    m_edge = 0;
  bit    m_active = 0;
  int    m_n, m_h = 0, m_issued, m_next_ok, m_age;
  int    m_cnt = 0;
  outs_t m_exp;

  task automatic model_step(input ins_t in, input logic rst);
    outs_t x;
    x = '0;
    m_edge++;
    if (rst) begin
      m_active = 0;
      m_h      = 0;
      m_cnt    = 0;
      m_exp    = '0;
      return;
    end
    if (!m_active) begin
      if (in.st) begin
        m_active   = 1;
        m_n        = (in.num == 0) ? 1 : ((int'(in.num) > MAXH) ? MAXH : int'(in.num));
        m_h        = 0;
        m_issued   = 0;
        m_age      = 0;
        m_next_ok  = m_edge + 1;
        x.next     = 1'b1;
        x.clear    = 1'b1;
        x.srestart = 1'b1;
      end
    end else begin
      if (in.st) x.overrun = 1'b1;
      if (m_age == WD - 1) begin
        x.timeout = 1'b1;
        m_active  = 0;
      end else begin
        if (m_issued < m_n) begin
          if (m_edge >= m_next_ok && in.sr && in.ar[m_h%2]) begin
            x.astart[m_h%2] = 1'b1;
            x.next          = 1'b1;
            m_h++;
            m_issued++;
            m_next_ok = m_edge + 2;
          end else if (m_issued > 0 && m_edge == m_next_ok - 1) begin
            x.sstart = 1'b1;
          end
        end else if (m_edge >= m_next_ok && in.ar == 2'b11) begin
          x.done   = 1'b1;
          m_active = 0;
        end
        m_age++;
      end
    end
    x.harm = 8'(m_h);
    x.busy = m_active;
    if (x.overrun && m_cnt < 65535) m_cnt++;
    if (x.timeout && m_cnt < 65535) m_cnt++;
    m_exp = x;
  endtask

  function automatic outs_t sample_outs();
    outs_t o;
    o.harm     = bus.o_harmonic;
    o.next     = bus.o_next_sample;
    o.astart   = bus.o_adder_start;
    o.clear    = bus.o_adder_clear;
    o.sstart   = bus.o_scaler_start;
    o.srestart = bus.o_scaler_restart;
    o.done     = bus.o_frame_done;
    o.busy     = bus.o_busy;
    o.overrun  = bus.o_overrun;
    o.timeout  = bus.o_timeout;
    return o;
  endfunction

  task automatic check(input string name, input outs_t act, input outs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, m_edge);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input ins_t in, input logic rst, output outs_t act);
    @(negedge clock);
    reset               = rst;
    bus.i_frame_start   = in.st;
    bus.i_num_harmonics = in.num;
    bus.i_sample_ready  = in.sr;
    bus.i_adder_ready   = in.ar;
    model_step(in, rst);
    @(posedge clock);
    #1;
    act = sample_outs();
`ifdef OVERRUN_STATS_EN
    check_int("overrun_count", int'(bus.o_overrun_count), m_cnt);
`endif
  endtask

  task automatic tickm(input string name, input ins_t in, output outs_t act);
    tick(in, 1'b0, act);
    check(name, act, m_exp);
  endtask

  function automatic ins_t mi(input logic st, input int num, input logic sr, input logic [1:0] ar);
    ins_t i;
    i.st  = st;
    i.num = 8'(num);
    i.sr  = sr;
    i.ar  = ar;
    return i;
  endfunction

  function automatic outs_t mo(input int harm, input logic nx, input logic [1:0] as,
                               input logic cl, input logic ss, input logic sr, input logic dn,
                               input logic bz);
    outs_t o;
    o          = '0;
    o.harm     = 8'(harm);
    o.next     = nx;
    o.astart   = as;
    o.clear    = cl;
    o.sstart   = ss;
    o.srestart = sr;
    o.done     = dn;
    o.busy     = bz;
    return o;
  endfunction

  vec_t  vecs[15];
  outs_t act;
  ins_t  in;

  initial begin
    int ovr, done_edge, tmo, tmo_edge, dones, starts, maxh, bad_sr, guard;
    int seq[$];
    reset = 1'b1;
    bus.i_frame_start = 1'b0;
    bus.i_num_harmonics = '0;
    bus.i_sample_ready = 1'b0;
    bus.i_adder_ready = 2'b00;

    // N=4 with readies high, then requested count 0 clamped to one harmonic.
    vecs[0]  = '{mi(1, 4, 1, 2'b11), mo(0, 1, 2'b00, 1, 0, 1, 0, 1)};
    vecs[1]  = '{mi(0, 4, 1, 2'b11), mo(1, 1, 2'b01, 0, 0, 0, 0, 1)};
    vecs[2]  = '{mi(0, 4, 1, 2'b11), mo(1, 0, 2'b00, 0, 1, 0, 0, 1)};
    vecs[3]  = '{mi(0, 4, 1, 2'b11), mo(2, 1, 2'b10, 0, 0, 0, 0, 1)};
    vecs[4]  = '{mi(0, 4, 1, 2'b11), mo(2, 0, 2'b00, 0, 1, 0, 0, 1)};
    vecs[5]  = '{mi(0, 4, 1, 2'b11), mo(3, 1, 2'b01, 0, 0, 0, 0, 1)};
    vecs[6]  = '{mi(0, 4, 1, 2'b11), mo(3, 0, 2'b00, 0, 1, 0, 0, 1)};
    vecs[7]  = '{mi(0, 4, 1, 2'b11), mo(4, 1, 2'b10, 0, 0, 0, 0, 1)};
    vecs[8]  = '{mi(0, 4, 1, 2'b11), mo(4, 0, 2'b00, 0, 0, 0, 0, 1)};
    vecs[9]  = '{mi(0, 4, 1, 2'b11), mo(4, 0, 2'b00, 0, 0, 0, 1, 0)};
    vecs[10] = '{mi(0, 4, 1, 2'b11), mo(4, 0, 2'b00, 0, 0, 0, 0, 0)};
    vecs[11] = '{mi(1, 0, 1, 2'b11), mo(0, 1, 2'b00, 1, 0, 1, 0, 1)};
    vecs[12] = '{mi(0, 0, 1, 2'b11), mo(1, 1, 2'b01, 0, 0, 0, 0, 1)};
    vecs[13] = '{mi(0, 0, 1, 2'b11), mo(1, 0, 2'b00, 0, 0, 0, 0, 1)};
    vecs[14] = '{mi(0, 0, 1, 2'b11), mo(1, 0, 2'b00, 0, 0, 0, 1, 0)};

    tick(mi(0, 0, 0, 2'b00), 1'b1, act);
    tick(mi(0, 0, 0, 2'b00), 1'b1, act);
    check("reset_state", act, '0);

    for (int i = 0; i < 15; i++) begin
      tick(vecs[i].in, 1'b0, act);
      check($sformatf("vec%0d", i), act, vecs[i].exp);
    end

    // Second frame_start mid-frame: overrun pulse, original frame unaffected.
    ovr = 0;
    done_edge = -1;
    for (int e = 0; e < 12; e++) begin
      tickm("overrun_seq", mi(e == 0 || e == 3, 4, 1, 2'b11), act);
      if (act.overrun) ovr++;
      if (act.done) done_edge = e;
    end
    check_int("overrun_pulses", ovr, 1);
    check_int("overrun_done_edge", done_edge, 9);
`ifdef OVERRUN_STATS_EN
    check_int("overrun_count_one", int'(bus.o_overrun_count), 1);
`endif

    // Reset mid-frame, then a clean frame.
    for (int e = 0; e < 4; e++) tickm("pre_reset", mi(e == 0, 4, 1, 2'b11), act);
    tick(mi(0, 4, 1, 2'b11), 1'b1, act);
    check("reset_mid", act, '0);
    dones = 0;
    for (int e = 0; e < 20; e++) begin
      tickm("post_reset", mi(e == 0, 4, 1, 2'b11), act);
      if (act.done) dones++;
    end
    check_int("post_reset_done", dones, 1);

    // Clamp to MAX_HARMONICS.
    starts = 0;
    maxh = -1;
    guard = 0;
    tickm("clamp", mi(1, 200, 1, 2'b11), act);
    while (act.busy && guard < 300) begin
      tickm("clamp", mi(0, 200, 1, 2'b11), act);
      if (act.astart != 2'b00) begin
        starts++;
        if (int'(act.harm) - 1 > maxh) maxh = int'(act.harm) - 1;
      end
      guard++;
    end
    check_int("clamp_starts", starts, 64);
    check_int("clamp_max_harm", maxh, 63);
    check_int("clamp_finished", int'(act.busy), 0);

    // Adder 1 never ready: stall at harmonic 1 until the watchdog fires.
    tmo = 0;
    tmo_edge = -1;
    dones = 0;
    for (int e = 0; e < WD + 6; e++) begin
      tickm("stall", mi(e == 0, 4, 1, 2'b01), act);
      if (act.timeout) begin
        tmo++;
        tmo_edge = e;
        check_int("stall_harm", int'(act.harm), 1);
      end
      if (act.done) dones++;
    end
    check_int("stall_timeouts", tmo, 1);
    check_int("stall_timeout_edge", tmo_edge, WD);
    check_int("stall_no_done", dones, 0);

    // Sparse sample_ready with adders dropping out.
    bad_sr = 0;
    done_edge = -1;
    for (int e = 0; e < 30; e++) begin
      in = mi(e == 0, 3, (e % 3) == 1,
              (e >= 7 && e < 12) ? 2'b10 : ((e >= 14 && e < 20) ? 2'b01 : 2'b11));
      tickm("sparse", in, act);
      if (act.astart == 2'b01) seq.push_back(0);
      if (act.astart == 2'b10) seq.push_back(1);
      if (act.astart != 2'b00 && !in.sr) bad_sr++;
      if (act.done) done_edge = e;
    end
    check_int("sparse_issue_count", seq.size(), 3);
    if (seq.size() == 3) begin
      check_int("sparse_order0", seq[0], 0);
      check_int("sparse_order1", seq[1], 1);
      check_int("sparse_order2", seq[2], 0);
    end
    check_int("sparse_bad_sr", bad_sr, 0);
    check_int("sparse_done_edge", done_edge, 20);

    // Randomized frames against the model.
    for (int f = 0; f < 12; f++) begin
      guard = 0;
      tickm("rand", mi(1, $urandom_range(0, 80), 1, 2'b11), act);
      while (act.busy && guard < 400) begin
        in = mi(($urandom_range(0, 39) == 0), $urandom_range(0, 255),
                ($urandom_range(0, 3) != 0),
                {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)});
        tickm("rand", in, act);
        guard++;
      end
      check_int("rand_frame_ended", int'(act.busy), 0);
      tickm("rand_idle", mi(0, 0, 1, 2'b11), act);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/harmonic_scheduler.md
Name: harmonic_scheduler

Overview:
Frame-level sequencer for the additive-synthesis datapath. Once per output sample it walks harmonic indices 0..N-1 through the sample-position generator and ping-pongs the scaled samples into two scaling Adders: even harmonics to adder 0, odd to adder 1. It also drives the harmonic-scale multiplier's start/restart and reports frame completion, overrun and timeout to the top level, which owns DAC timing.

Parameters:
HARM_BITS, 8, width of harmonic index and count
MAX_HARMONICS, 64, upper clamp on harmonics per frame
WATCHDOG_CYCLES, 1500, max cycles a frame may stay active before abort (one sample interval at 72 MHz / 48 kHz)

Ports:
i_clock  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_frame_start  in  1  one-cycle pulse: begin a new frame
i_num_harmonics  in  HARM_BITS  harmonics requested, sampled on i_frame_start
i_sample_ready  in  1  sample-position value valid
i_adder_ready  in  2  per-adder idle/done flags
o_harmonic  out  HARM_BITS  harmonic index presented to sample-position block
o_next_sample  out  1  one-cycle pulse: advance sample-position block
o_adder_start  out  2  one-cycle start pulse per adder
o_adder_clear  out  1  one-cycle accumulator clear
o_scaler_start  out  1  one-cycle pulse: step the harmonic-scale multiplier
o_scaler_restart  out  1  one-cycle pulse: reload the multiplier's initial value
o_frame_done  out  1  one-cycle pulse: both accumulators final
o_busy  out  1  high when not IDLE
o_overrun  out  1  one-cycle pulse: i_frame_start arrived while busy
o_timeout  out  1  one-cycle pulse: watchdog abort

Behaviour:
- All outputs registered. Reset value of every output is 0, state is IDLE, and the internal count is 0. Reset mid-frame aborts immediately with no o_frame_done.
- Count latch: on accepted i_frame_start, N = clamp(i_num_harmonics, 1, MAX_HARMONICS).
- States:
  - IDLE: on i_frame_start, latch N, set o_harmonic=0, pulse o_adder_clear, o_scaler_restart and o_next_sample, then go to ISSUE.
  - ISSUE: wait for i_sample_ready && i_adder_ready[o_harmonic[0]]. On that cycle pulse o_adder_start[o_harmonic[0]] and o_next_sample, and increment o_harmonic. If the issued index == N-1, go to DRAIN; otherwise go to STEP.
  - STEP: one cycle. Pulse o_scaler_start, then go to ISSUE. This gives the adder ready flags one cycle to drop.
  - DRAIN: one cycle, then go to FINISH.
  - FINISH: wait until i_adder_ready == 2'b11, pulse o_frame_done, return to IDLE.
- Latency: with i_frame_start sampled at edge k and all readies held high, harmonic h issues at edge k+1+2h and o_frame_done is high after edge k+2N+1.
- i_frame_start in any non-IDLE state, including the FINISH completion cycle, is ignored and pulses o_overrun. The frame in progress is unaffected.
- Watchdog counter: cleared on entry from IDLE and increments every active cycle. When it reaches WATCHDOG_CYCLES-1, pulse o_timeout, drop all start pulses and return to IDLE. Timeout takes priority over issue/done in the same cycle.
- o_harmonic never exceeds N-1 as an issued index. After the last issue it holds N until the next frame.

Optional Feature:
OVERRUN_STATS_EN
- Defined: adds output o_overrun_count (16 bits, reset 0, saturating at 16'hFFFF). It increments on every o_overrun or o_timeout pulse and is cleared only by i_reset.
- Undefined: the port and counter are absent, and the rest of the behaviour is identical.

Decomposition:
- Shared package addatone_pkg holds:
  - the state enum (IDLE, ISSUE, STEP, DRAIN, FINISH);
  - NUM_ADDERS = 2;
  - the DEFAULT_SAMPLE_INTERVAL = 1500 constant.
- One natural sub-module, frame_watchdog: a loadable down-counter with terminal pulse, parameterised by WATCHDOG_CYCLES.

Test Plan:
- N=4, readies held high, frame_start at edge 0:
  - o_adder_start[0] at edges 1 and 5, [1] at edges 3 and 7;
  - o_scaler_start at edges 2, 4 and 6;
  - o_frame_done after edge 9; o_busy low afterward.
- i_num_harmonics=0 -> one issue (adder 0) and frame_done after edge 3. Separately, i_num_harmonics=200 -> exactly 64 start pulses, max o_harmonic issued = 63.
- Hold i_adder_ready[1]=0 with N=4 and WATCHDOG_CYCLES=100 -> stall in ISSUE at harmonic 1, o_timeout at cycle 99, IDLE, no frame_done.
- frame_start pulsed at edge 3 of an N=4 frame -> o_overrun one cycle, original frame still completes at edge 9; with OVERRUN_STATS_EN, count = 1.
- i_reset asserted at edge 4 mid-frame -> all outputs 0 next cycle, o_busy=0; a subsequent frame_start runs a full frame normally.
- i_sample_ready toggling 1-in-3 cycles with N=3 -> starts only on ready cycles, strict alternation 0,1,0, and frame_done only after both adders ready.
